// File: rtl/jk_arb_pkg.sv
// Shared op/state encodings for the JK register arbiter and its J/K decode helper.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package jk_arb_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_CLR  = 2'b01,
        OP_SET  = 2'b10,
        OP_TGL  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_APPLY = 2'b01,
        S_ACK   = 2'b10
    } state_e;

    // Returns {j, k} for a masked-in bit under the given command.
    function automatic logic [1:0] jk_of(input op_e op);
        case (op)
            OP_CLR:  return 2'b01;
            OP_SET:  return 2'b10;
            OP_TGL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/jk_reg_arbiter_if.sv
// Requester-side bundle of the JK register arbiter: requests, commands, grants, acks, register view.
// Latency: n/a (wiring only).
// Backpressure: req is held by each requester until its ack pulse.
interface jk_reg_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] mask;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [WIDTH-1:0]      q;

    modport master (output req, op, mask, input gnt, ack, busy, q);
    modport slave  (input req, op, mask, output gnt, ack, busy, q);
endinterface

// File: rtl/jk_ff.sv
// Single JK flip-flop cell with asynchronous active-high reset.
// Latency: q updates at the clock edge following j/k.
// Backpressure: none.
module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end
endmodule

// File: rtl/jk_reg_arbiter.sv
// Round-robin arbiter applying one requester's masked hold/clear/set/toggle to a shared JK register.
// Latency: req sampled in IDLE, gnt next cycle, ack plus new q the cycle after; one command per 3 cycles.
// Backpressure: requesters hold req until ack; losers simply wait, nothing is dropped.
module jk_reg_arbiter
    import jk_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic             clk,
    input  logic             rst,
    jk_reg_arbiter_if.slave  bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   win;
    op_e               lat_op;
    logic [WIDTH-1:0]  lat_mask;
    logic [NREQ-1:0]   gnt_r;
    logic [NREQ-1:0]   ack_r;
    logic              busy_r;

    logic              pick_vld;
    logic [IDXW-1:0]   pick_idx;
    int                cand;

    logic [WIDTH-1:0]  j_bits;
    logic [WIDTH-1:0]  k_bits;
    logic [WIDTH-1:0]  q_bits;
    logic [1:0]        jk_sel;
    logic              ff_rst;

    // First requesting index found walking upward from ptr, wrapping at NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int n = 0; n < NREQ; n++) begin
            cand = int'(ptr) + n;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = IDXW'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            win      <= '0;
            lat_op   <= OP_HOLD;
            lat_mask <= '0;
            gnt_r    <= '0;
            ack_r    <= '0;
            busy_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        win      <= pick_idx;
                        lat_op   <= op_e'(bus.op[2*int'(pick_idx) +: 2]);
                        lat_mask <= bus.mask[WIDTH*int'(pick_idx) +: WIDTH];
                        gnt_r    <= NREQ'(1) << pick_idx;
                        busy_r   <= 1'b1;
                        state    <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    gnt_r <= '0;
                    ack_r <= gnt_r;
                    state <= S_ACK;
                end
                S_ACK: begin
                    ack_r  <= '0;
                    busy_r <= 1'b0;
                    ptr    <= (win == IDXW'(NREQ - 1)) ? '0 : win + IDXW'(1);
                    state  <= S_IDLE;
                end
                default: begin
                    gnt_r  <= '0;
                    ack_r  <= '0;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // J/K are only ever nonzero during APPLY, so the bank holds in every other state.
    always_comb begin
        jk_sel = jk_of(lat_op);
        j_bits = '0;
        k_bits = '0;
        if (state == S_APPLY) begin
            j_bits = lat_mask & {WIDTH{jk_sel[1]}};
            k_bits = lat_mask & {WIDTH{jk_sel[0]}};
        end
    end

    assign ff_rst = ~rst;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bank
        jk_ff u_ff (
            .clk (clk),
            .rst (ff_rst),
            .j   (j_bits[b]),
            .k   (k_bits[b]),
            .q   (q_bits[b])
        );
    end

    assign bus.gnt  = gnt_r;
    assign bus.ack  = ack_r;
    assign bus.busy = busy_r;
    assign bus.q    = q_bits;

endmodule

// File: tb/tb_jk_reg_arbiter.sv
// Scenario bench for jk_reg_arbiter against a queue-free behavioural model (round-robin pick + bitwise op).
module tb_jk_reg_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jk_reg_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
    jk_reg_arbiter #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;
    logic [W-1:0] mq;
    int mptr;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int n = 0; n < N; n++) begin
            if (r[(p + n) % N]) return (p + n) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] apply_cmd(input logic [W-1:0] cur, input logic [1:0] o, input logic [W-1:0] m);
        case (o)
            2'b00:   return cur;
            2'b01:   return cur & ~m;
            2'b10:   return cur | m;
            default: return cur ^ m;
        endcase
    endfunction

    task automatic set_slot(input int i, input logic [1:0] o, input logic [W-1:0] m);
        bus.op[2*i +: 2]  = o;
        bus.mask[W*i +: W] = m;
    endtask

    // Drives one lone request through the full handshake and reports what was seen.
    task automatic run_one(input int i, input logic [1:0] o, input logic [W-1:0] m,
                           output logic [N-1:0] g1, output logic [W-1:0] q1,
                           output logic [N-1:0] a2, output logic [W-1:0] q2,
                           output logic [N-1:0] a3, output logic b3);
        set_slot(i, o, m);
        bus.req    = '0;
        bus.req[i] = 1'b1;
        step; g1 = bus.gnt; q1 = bus.q;
        step; a2 = bus.ack; q2 = bus.q;
        bus.req = '0;
        step; a3 = bus.ack; b3 = bus.busy;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.req  = N'($urandom);
        bus.op   = (2*N)'($urandom);
        bus.mask = (W*N)'($urandom);
        #23;
        tests++; if (bus.q !== 8'h00)  begin fails++; $display("FAIL reset_q got=%h exp=00", bus.q); end
        tests++; if (bus.gnt !== 4'h0) begin fails++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        tests++; if (bus.ack !== 4'h0) begin fails++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        bus.req = '0;
        step;
        rst = 1'b1;
        step; step; step;
        tests++; if ({bus.q, bus.gnt, bus.ack, bus.busy} !== '0)
            begin fails++; $display("FAIL post_reset_idle got q=%h gnt=%b ack=%b busy=%b exp all 0", bus.q, bus.gnt, bus.ack, bus.busy); end
        mq = '0; mptr = 0;
    endtask

    task automatic test_single_set;
        logic [N-1:0] g1, a2, a3; logic [W-1:0] q1, q2; logic b3;
        run_one(0, 2'b10, 8'hF0, g1, q1, a2, q2, a3, b3);
        tests++; if (g1 !== 4'b0001) begin fails++; $display("FAIL set_gnt got=%b exp=0001", g1); end
        tests++; if (q1 !== 8'h00)   begin fails++; $display("FAIL set_q_cycle1 got=%h exp=00", q1); end
        tests++; if (a2 !== 4'b0001) begin fails++; $display("FAIL set_ack got=%b exp=0001", a2); end
        tests++; if (q2 !== 8'hF0)   begin fails++; $display("FAIL set_q got=%h exp=f0", q2); end
        tests++; if ({a3, b3} !== '0) begin fails++; $display("FAIL set_release got ack=%b busy=%b exp 0", a3, b3); end
        mq = 8'hF0; mptr = 1;
    endtask

    task automatic test_toggle_clear;
        logic [N-1:0] g1, a2, a3; logic [W-1:0] q1, q2; logic b3;
        run_one(1, 2'b11, 8'hFF, g1, q1, a2, q2, a3, b3);
        tests++; if (g1 !== 4'b0010 || a2 !== 4'b0010) begin fails++; $display("FAIL tgl_handshake got gnt=%b ack=%b exp 0010", g1, a2); end
        tests++; if (q2 !== 8'h0F) begin fails++; $display("FAIL tgl_q got=%h exp=0f", q2); end
        run_one(2, 2'b01, 8'h05, g1, q1, a2, q2, a3, b3);
        tests++; if (g1 !== 4'b0100 || a2 !== 4'b0100) begin fails++; $display("FAIL clr_handshake got gnt=%b ack=%b exp 0100", g1, a2); end
        tests++; if (q2 !== 8'h0A) begin fails++; $display("FAIL clr_q got=%h exp=0a", q2); end
        mq = 8'h0A; mptr = 3;
    endtask

    task automatic test_null_cmd;
        logic [N-1:0] g1, a2, a3; logic [W-1:0] q1, q2; logic b3;
        run_one(3, 2'b10, 8'h00, g1, q1, a2, q2, a3, b3);
        tests++; if (a2 !== 4'b1000) begin fails++; $display("FAIL null_ack got=%b exp=1000", a2); end
        tests++; if (q2 !== mq) begin fails++; $display("FAIL null_q got=%h exp=%h", q2, mq); end
        mptr = 0;
    endtask

    task automatic test_contention;
        logic [1:0] ops [N];
        logic [W-1:0] msk [N];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int acks = 0, last_cyc = -1, idle_run = 0, max_idle = 0, pw = 0;
        logic [W-1:0] pq = '0;
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            ops[i] = 2'($urandom); msk[i] = W'($urandom);
            set_slot(i, ops[i], msk[i]);
        end
        bus.req = '1;
        step;
        mq = '0; mptr = 0;
        rst = 1'b1;
        for (int cyc = 0; cyc < 40 && acks < 5; cyc++) begin
            step;
            if (bus.gnt !== '0) begin
                pw = rr_pick(bus.req, mptr);
                tests++; if (bus.gnt !== (4'b0001 << pw)) begin fails++; $display("FAIL cont_gnt got=%b exp_idx=%0d", bus.gnt, pw); end
                pq = apply_cmd(mq, ops[pw], msk[pw]);
                ops[pw] = ops[pw] ^ 2'b11;
                msk[pw] = ~msk[pw];
                set_slot(pw, ops[pw], msk[pw]);
            end
            if (bus.ack !== '0) begin
                tests++; if (bus.ack !== (4'b0001 << exp_order[acks])) begin fails++; $display("FAIL cont_ack_order got=%b exp_idx=%0d", bus.ack, exp_order[acks]); end
                tests++; if (bus.q !== pq) begin fails++; $display("FAIL cont_q got=%h exp=%h", bus.q, pq); end
                if (acks > 0) begin
                    tests++; if (cyc - last_cyc !== 3) begin fails++; $display("FAIL cont_ack_spacing got=%0d exp=3", cyc - last_cyc); end
                end
                last_cyc = cyc; mq = pq; mptr = (pw + 1) % N; acks++;
            end
            if (bus.busy !== 1'b1) begin
                idle_run++;
                if (idle_run > max_idle) max_idle = idle_run;
            end else idle_run = 0;
        end
        tests++; if (acks !== 5) begin fails++; $display("FAIL cont_budget got=%0d acks exp=5", acks); end
        tests++; if (max_idle > 1) begin fails++; $display("FAIL cont_busy_gap got=%0d exp<=1", max_idle); end
        bus.req = '0;
        step; step;
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] seen_ack = '0;
        logic [W-1:0] m2;
        set_slot(2, 2'b10, 8'hFF);
        bus.req = 4'b0100;
        step;
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL mid_gnt got=%b exp=0100", bus.gnt); end
        rst = 1'b0;
        #1;
        tests++; if ({bus.q, bus.gnt, bus.busy} !== '0) begin fails++; $display("FAIL mid_async got q=%h gnt=%b busy=%b exp 0", bus.q, bus.gnt, bus.busy); end
        for (int i = 0; i < 3; i++) begin step; seen_ack |= bus.ack; end
        tests++; if (seen_ack !== '0) begin fails++; $display("FAIL mid_no_ack got=%b exp=0000", seen_ack); end
        m2 = W'($urandom);
        set_slot(1, 2'b10, 8'h3C);
        set_slot(2, 2'b11, m2);
        bus.req = 4'b0110;
        rst = 1'b1;
        mq = '0; mptr = 0;
        step;
        tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL mid_first_gnt got=%b exp=0010", bus.gnt); end
        step;
        tests++; if (bus.ack !== 4'b0010 || bus.q !== 8'h3C) begin fails++; $display("FAIL mid_first_ack got ack=%b q=%h exp 0010/3c", bus.ack, bus.q); end
        bus.req[1] = 1'b0;
        step; step;
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL mid_second_gnt got=%b exp=0100", bus.gnt); end
        step;
        tests++; if (bus.q !== apply_cmd(8'h3C, 2'b11, m2)) begin fails++; $display("FAIL mid_second_q got=%h exp=%h", bus.q, apply_cmd(8'h3C, 2'b11, m2)); end
        mq = apply_cmd(8'h3C, 2'b11, m2); mptr = 3;
        bus.req = '0;
        step;
    endtask

    task automatic test_random;
        logic [N-1:0] r;
        logic [W-1:0] expq;
        int w;
        for (int t = 0; t < 30; t++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            bus.op   = (2*N)'($urandom);
            bus.mask = (W*N)'($urandom);
            w = rr_pick(r, mptr);
            expq = apply_cmd(mq, bus.op[2*w +: 2], bus.mask[W*w +: W]);
            bus.req = r;
            step;
            tests++; if (bus.gnt !== (4'b0001 << w) || bus.busy !== 1'b1) begin fails++; $display("FAIL rnd_gnt t=%0d got=%b busy=%b exp_idx=%0d", t, bus.gnt, bus.busy, w); end
            bus.op   = (2*N)'($urandom);
            bus.mask = (W*N)'($urandom);
            bus.req  = N'($urandom);
            step;
            tests++; if (bus.ack !== (4'b0001 << w)) begin fails++; $display("FAIL rnd_ack t=%0d got=%b exp_idx=%0d", t, bus.ack, w); end
            tests++; if (bus.q !== expq) begin fails++; $display("FAIL rnd_q t=%0d got=%h exp=%h", t, bus.q, expq); end
            bus.req = '0;
            step;
            tests++; if (bus.busy !== 1'b0 || bus.ack !== '0) begin fails++; $display("FAIL rnd_idle t=%0d got busy=%b ack=%b exp 0", t, bus.busy, bus.ack); end
            mq = expq; mptr = (w + 1) % N;
        end
    endtask

    initial begin
        bus.req = '0; bus.op = '0; bus.mask = '0;
        test_reset;
        test_single_set;
        test_toggle_clear;
        test_null_cmd;
        test_contention;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
